// File: rtl/rise_event_counter_pkg.sv
// rtl/rise_event_counter_pkg.sv - shared constants and snapshot FSM states for rise_event_counter
package rise_event_counter_pkg;

    localparam int DEFAULT_WIDTH       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } snap_state_e;

endpackage

// File: rtl/rise_event_counter_rise_detect.sv
// rtl/rise_event_counter_rise_detect.sv - din synchronizer, previous-sample register and a'.b rise term
import rise_event_counter_pkg::*;

module rise_event_counter_rise_detect #(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   din_s;

    assign din_s = sync_q[SYNC_STAGES-1];

    // Shift din through the chain; prev follows the synchronized sample every cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = din_s;
    end

    // Chain and prev reset high so a din that is already high never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // a'.b with a = previous sample, b = current sample
    assign rise_c = ~prev_q & din_s;

endmodule

// File: rtl/rise_event_counter.sv
// rtl/rise_event_counter.sv - rising-edge event counter with sticky overflow and snapshot handshake
import rise_event_counter_pkg::*;

module rise_event_counter #(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SATURATE    = 0,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             enable,
    input  logic             clear,
    output logic             rise,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    input  logic             snap_req,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_data,
    input  logic             snap_ack
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             rise_c;
    logic             counted;
    logic             rise_q;
    logic             rise_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [WIDTH-1:0] snap_data_q;
    logic [WIDTH-1:0] snap_data_d;
    snap_state_e      state_q;
    snap_state_e      state_d;

    rise_event_counter_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rise_detect (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .rise_c (rise_c)
    );

    assign counted = rise_c & enable;

    // Counter, overflow and rise pulse: clear beats a coincident rise, which is dropped
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        rise_d     = 1'b0;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (counted) begin
            rise_d = 1'b1;
            if (count_q == CNT_MAX) begin
                overflow_d = 1'b1;
                count_d    = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Snapshot FSM: capture the pre-update count on entry to HOLD, release on ack
    always_comb begin
        state_d     = state_q;
        snap_data_d = snap_data_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    state_d     = ST_HOLD;
                    snap_data_d = count_q;
                end
            end
            ST_HOLD: begin
                if (snap_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also aborts any held snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q      <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            snap_data_q <= '0;
            state_q     <= ST_IDLE;
        end else begin
            rise_q      <= rise_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            snap_data_q <= snap_data_d;
            state_q     <= state_d;
        end
    end

    assign rise       = rise_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign snap_valid = (state_q == ST_HOLD);
    assign snap_data  = snap_data_q;

endmodule
